// File: rtl/sram_read_aligner.sv
// Read-data aligner for the configurable-aspect SRAM wrapper: tags each macro read, extracts the
// addressed lane on return and queues it behind a credit-throttled FIFO. Build option: SRAM_ALIGN_ZERO_FILL_EN.
module sram_read_aligner #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = $clog2(DATA_W),
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_conf,
  input  logic [SEL_W-1:0]  req_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [2:0]       MAX_CONF  = 3'(SEL_W);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic             tag_valid_reg [RD_LAT];
  logic [2:0]       tag_conf_reg  [RD_LAT];
  logic [SEL_W-1:0] tag_addr_reg  [RD_LAT];

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic              fifo_err  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  fifo_cnt_reg, fifo_cnt_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              req_ready_reg;

  logic              accept, push, pop;
  logic [2:0]        exit_conf;
  logic [SEL_W-1:0]  exit_addr;
  logic [SEL_W-1:0]  lane_mask, lane;
  logic [SEL_W:0]    width;
  logic [2*SEL_W:0]  shift;
  logic [DATA_W-1:0] field_mask, field, aligned;
  logic              aligned_err;

  assign accept    = req_valid && req_ready_reg;
  assign push      = tag_valid_reg[RD_LAT-1];
  assign exit_conf = tag_conf_reg[RD_LAT-1];
  assign exit_addr = tag_addr_reg[RD_LAT-1];
  assign out_valid = (fifo_cnt_reg != '0);
  assign pop       = out_valid && out_ready;
  assign req_ready = req_ready_reg;
  assign out_data  = out_valid ? fifo_data[rd_ptr_reg] : '0;
  assign out_err   = out_valid ? fifo_err[rd_ptr_reg] : 1'b0;

  // Tag pipeline mirrors the macro latency so the tag exits exactly when its data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_valid_reg[i] <= 1'b0;
    end else begin
      tag_valid_reg[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) tag_valid_reg[i] <= tag_valid_reg[i-1];
    end
    tag_conf_reg[0] <= req_conf;
    tag_addr_reg[0] <= req_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_conf_reg[i] <= tag_conf_reg[i-1];
      tag_addr_reg[i] <= tag_addr_reg[i-1];
    end
  end

  always_comb begin
    lane_mask   = ~({SEL_W{1'b1}} << exit_conf);
    lane        = exit_addr & lane_mask;
    width       = (SEL_W+1)'(DATA_W) >> exit_conf;
    shift       = {{(SEL_W+1){1'b0}}, lane} * {{SEL_W{1'b0}}, width};
    field_mask  = ~({DATA_W{1'b1}} << width);
    field       = (mem_dout >> shift) & field_mask;
    aligned     = mem_dout;
    aligned_err = 1'b1;
    if (exit_conf <= MAX_CONF) begin
      aligned_err = 1'b0;
`ifdef SRAM_ALIGN_ZERO_FILL_EN
      aligned = field;
`else
      // Legacy wrappers expect the bits above the field to pass through untouched.
      aligned = field | (mem_dout & ~field_mask);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= aligned;
      fifo_err[wr_ptr_reg]  <= aligned_err;
    end
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt_reg;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt_reg - 1'b1;
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Credits cover both in-flight tags and stored results, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_cnt_reg  <= '0;
      count_reg     <= '0;
      req_ready_reg <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      fifo_cnt_reg  <= fifo_cnt_next;
      count_reg     <= count_next;
      req_ready_reg <= (count_next < DEPTH_CNT);
    end
  end

endmodule

// File: tb/tb_sram_read_aligner.sv
// Scoreboard bench for sram_read_aligner: directed reads with hand-computed results, checked in order.
module tb_sram_read_aligner;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_conf;
  logic [SEL_W-1:0]  req_addr;
  logic [DATA_W-1:0] mem_dout = '0;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  sram_read_aligner #(.DATA_W(DATA_W), .RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_conf(req_conf), .req_addr(req_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_total = 0;
  logic [31:0] req_data, exp_data;
  logic        exp_err;
  logic        acc_now = 1'b0;
  logic [31:0] data_now = '0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: records accepted requests into the scoreboard and checks every handshake.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (dut.count_reg > DEPTH) begin
      errors++;
      $display("FAIL credit_bound: count %0d, must be <= %0d", dut.count_reg, DEPTH);
    end
    if (rst) begin
      exp_q.delete();
      acc_now   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, hold_data);
        check("hold_err", 32'(out_err), 32'(hold_err));
      end
      acc_now = req_valid && req_ready;
      if (acc_now) begin
        e.err  = exp_err;
        e.data = exp_data;
        exp_q.push_back(e);
        data_now = req_data;
        acc_total++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data 0x%08h err %0b, expected no result", out_data, out_err);
        end else begin
          e = exp_q.pop_front();
          check("result_data", out_data, e.data);
          check("result_err", 32'(out_err), 32'(e.err));
          $display("result data=0x%08h err=%0b", out_data, out_err);
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_err  = out_err;
    end
  end

  // Macro model: returns the accepted read's word one cycle later, noise otherwise.
  always @(posedge clk) begin
    logic        a;
    logic [31:0] d;
    a = acc_now;
    d = data_now;
    #1 mem_dout = a ? d : $urandom();
  end

  task automatic issue(input logic [2:0] c, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] e, input logic er);
    int waited = 0;
    req_conf  = c;
    req_addr  = a;
    req_data  = d;
    exp_data  = e;
    exp_err   = er;
    req_valid = 1'b1;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: req_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    logic [31:0] e;
    int base;
    rst = 1'b1; req_valid = 1'b0; req_conf = '0; req_addr = '0; out_ready = 1'b0;
    req_data = '0; exp_data = '0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);

    // Latency: accept at N, out_valid at N+2.
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_conf = 3'd0; req_addr = 5'd0; req_data = 32'hDEADBEEF;
    exp_data = 32'hDEADBEEF; exp_err = 1'b0; req_valid = 1'b1;
    @(negedge clk); check("lat_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); check("lat_n1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("lat_n2_valid", 32'(out_valid), 32'd1);
    wait_drain();

`ifdef SRAM_ALIGN_ZERO_FILL_EN
    issue(3'd2, 5'b00010, 32'hDEADBEEF, 32'h000000AD, 1'b0);
    issue(3'd2, 5'b11110, 32'hDEADBEEF, 32'h000000AD, 1'b0);
    issue(3'd1, 5'd1,     32'hCAFEF00D, 32'h0000CAFE, 1'b0);
    issue(3'd3, 5'd5,     32'h12345678, 32'h00000003, 1'b0);
    issue(3'd4, 5'h1D,    32'h0C000000, 32'h00000003, 1'b0);
`else
    issue(3'd2, 5'b00010, 32'hDEADBEEF, 32'hDEADBEAD, 1'b0);
    issue(3'd2, 5'b11110, 32'hDEADBEEF, 32'hDEADBEAD, 1'b0);
    issue(3'd1, 5'd1,     32'hCAFEF00D, 32'hCAFECAFE, 1'b0);
    issue(3'd3, 5'd5,     32'h12345678, 32'h12345673, 1'b0);
    issue(3'd4, 5'h1D,    32'h0C000000, 32'h0C000003, 1'b0);
`endif
    issue(3'd6, 5'd0,  32'h12345678, 32'h12345678, 1'b1);
    issue(3'd7, 5'd17, 32'h89ABCDEF, 32'h89ABCDEF, 1'b1);
    wait_drain();

    // Single-bit lanes: one-hot word, the addressed bit lands on bit 0.
    for (int a = 0; a < 32; a++) begin
`ifdef SRAM_ALIGN_ZERO_FILL_EN
      e = 32'h1;
`else
      e = 32'h1 | (32'h1 << a);
`endif
      issue(3'd5, 5'(a), 32'h1 << a, e, 1'b0);
    end
    wait_drain();

    // Back-pressure: only DEPTH requests get credits.
    out_ready = 1'b0;
    base = acc_total;
    for (int k = 0; k < 4; k++) begin
      req_conf = 3'd0; req_addr = 5'd0;
      req_data = 32'hA0000000 + 32'(k); exp_data = 32'hA0000000 + 32'(k); exp_err = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("bp_accepted", 32'(acc_total - base), 32'd2);
    check("bp_req_ready_low", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk); check("bp_ready_at_pop", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("bp_ready_after_pop", 32'(req_ready), 32'd1);
    wait_drain();

    // Reset with one result queued and one read in flight.
    out_ready = 1'b0;
    issue(3'd0, 5'd0, 32'h55AA55AA, 32'h55AA55AA, 1'b0);
    issue(3'd0, 5'd0, 32'h33CC33CC, 32'h33CC33CC, 1'b0);
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
`ifdef SRAM_ALIGN_ZERO_FILL_EN
    issue(3'd1, 5'd0, 32'hCAFEF00D, 32'h0000F00D, 1'b0);
`else
    issue(3'd1, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
`endif
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
